alu_cmd_ctrl: RTL and testbench

- Command sequencer directly upstream of the 16-bit arithmetic unit.
- Assembles operand/function frames from the received byte stream and issues a one-cycle enable to the arithmetic unit.
- Captures the registered result and flags, then returns result bytes to the transmit path over a valid/ready handshake.
- Single clock domain; the RX byte stream is already synchronised into `clk`.

---
 rtl/alu_ctrl_pkg.sv | 18 +
 rtl/alu_cmd_ctrl.sv | 107 ++++++++++
 tb/tb_alu_cmd_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and constants for the ALU command sequencer
//   state_t       - sequencer states
//   *_DEF         - default command/response bytes and timeout
//   ST_CARRY/OVR  - bit positions inside the status response byte
//   FUN_DIV       - function code of the divider
package alu_ctrl_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_A_LO, S_A_HI, S_B_LO, S_B_HI, S_FUN,
        S_EXEC, S_WAIT, S_TX_LO, S_TX_HI, S_TX_ST, S_TX_ERR
    } state_t;
    localparam int         TIMEOUT_DEF  = 4;
    localparam logic [7:0] CMD_OPER_DEF = 8'hCC;
    localparam logic [7:0] CMD_FUN_DEF  = 8'hDD;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;
    localparam int         ST_CARRY     = 0;
    localparam int         ST_OVR       = 1;
    localparam logic [3:0] FUN_DIV      = 4'b0011;
endpackage

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: byte-stream command sequencer in front of the 16-bit arithmetic unit
//   clk, RST (async, active-low)
//   RX_D/RX_D_VLD          - received command bytes
//   ALU_A/ALU_B/ALU_FUN    - held operands and function code to the unit
//   ALU_EN                 - one-cycle start pulse to the unit
//   ALU_OUT/ALU_CARRY/ALU_OUT_VLD - registered result from the unit
//   TX_D/TX_D_VLD/TX_RDY   - response bytes, valid/ready handshake
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int         TIMEOUT  = TIMEOUT_DEF,
    parameter logic [7:0] CMD_OPER = CMD_OPER_DEF,
    parameter logic [7:0] CMD_FUN  = CMD_FUN_DEF,
    parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [7:0]  RX_D,
    input  logic        RX_D_VLD,
    input  logic [15:0] ALU_OUT,
    input  logic        ALU_CARRY,
    input  logic        ALU_OUT_VLD,
    output logic [15:0] ALU_A,
    output logic [15:0] ALU_B,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_EN,
    output logic [7:0]  TX_D,
    output logic        TX_D_VLD,
    input  logic        TX_RDY
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, nxt;
    logic [15:0]   result;
    logic          carry, ovr, hs, busy;
    logic [CW-1:0] cnt;
    logic [7:0]    status;

    assign hs   = TX_D_VLD && TX_RDY;
    assign busy = state inside {S_EXEC, S_WAIT, S_TX_LO, S_TX_HI, S_TX_ST, S_TX_ERR};

    always_ff @(posedge clk or negedge RST)
        if (!RST) state <= S_IDLE;
        else      state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (RX_D_VLD) nxt = RX_D == CMD_OPER ? S_A_LO : RX_D == CMD_FUN ? S_FUN : S_IDLE;
            S_A_LO:   if (RX_D_VLD) nxt = S_A_HI;
            S_A_HI:   if (RX_D_VLD) nxt = S_B_LO;
            S_B_LO:   if (RX_D_VLD) nxt = S_B_HI;
            S_B_HI:   if (RX_D_VLD) nxt = S_FUN;
            // B is already held here, so the divide-by-zero test sees the frame's operand
            S_FUN:    if (RX_D_VLD) nxt = (RX_D[7:4] != 4'h0 || (RX_D[3:0] == FUN_DIV && ALU_B == 16'h0)) ? S_TX_ERR : S_EXEC;
            S_EXEC:   nxt = S_WAIT;
            // cnt counts completed WAIT cycles; leaving on the TIMEOUT-th one gives exactly TIMEOUT cycles
            S_WAIT:   nxt = ALU_OUT_VLD ? S_TX_LO : cnt == CW'(TIMEOUT - 1) ? S_TX_ERR : S_WAIT;
            S_TX_LO:  if (hs) nxt = S_TX_HI;
            S_TX_HI:  if (hs) nxt = S_TX_ST;
            S_TX_ST:  if (hs) nxt = S_IDLE;
            S_TX_ERR: if (hs) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST)
        if (!RST) begin
            ALU_A   <= '0;
            ALU_B   <= '0;
            ALU_FUN <= '0;
            result  <= '0;
            carry   <= 1'b0;
            ovr     <= 1'b0;
            cnt     <= '0;
        end else begin
            if (RX_D_VLD)
                case (state)
                    S_A_LO:  ALU_A[7:0]  <= RX_D;
                    S_A_HI:  ALU_A[15:8] <= RX_D;
                    S_B_LO:  ALU_B[7:0]  <= RX_D;
                    S_B_HI:  ALU_B[15:8] <= RX_D;
                    S_FUN:   ALU_FUN     <= RX_D[3:0];
                    default: ;
                endcase
            cnt <= state == S_WAIT ? cnt + 1'b1 : '0;
            if (state == S_WAIT && ALU_OUT_VLD) begin
                result <= ALU_OUT;
                carry  <= ALU_CARRY;
            end
            // ending a response wins over a coincident dropped byte
            if ((state == S_TX_ST || state == S_TX_ERR) && hs) ovr <= 1'b0;
            else if (RX_D_VLD && busy)                        ovr <= 1'b1;
        end

    always_comb begin
        status           = '0;
        status[ST_OVR]   = ovr;
        status[ST_CARRY] = carry;
        ALU_EN   = state == S_EXEC;
        TX_D_VLD = state inside {S_TX_LO, S_TX_HI, S_TX_ST, S_TX_ERR};
        TX_D     = state == S_TX_LO  ? result[7:0]  :
                   state == S_TX_HI  ? result[15:8] :
                   state == S_TX_ST  ? status       :
                   state == S_TX_ERR ? ERR_BYTE     : 8'h00;
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: directed and randomized self-checking bench for alu_cmd_ctrl
module tb_alu_cmd_ctrl;
    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_D = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT;
    logic        ALU_CARRY, ALU_OUT_VLD;
    logic [15:0] ALU_A, ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [7:0]  TX_D;
    logic        TX_D_VLD;
    logic        TX_RDY = 1'b1;

    int total = 0, bad = 0;
    logic [7:0] got[$];
    logic [7:0] expq[$];
    int en_cnt = 0, vld_cnt = 0;
    bit unit_on = 1'b1, rand_rdy = 1'b0;
    logic [15:0] ma = '0, mb = '0;
    logic [3:0]  mfun = '0;

    alu_cmd_ctrl dut (
        .clk(clk), .RST(RST), .RX_D(RX_D), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .ALU_CARRY(ALU_CARRY), .ALU_OUT_VLD(ALU_OUT_VLD),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .TX_D(TX_D), .TX_D_VLD(TX_D_VLD), .TX_RDY(TX_RDY)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] unit_f(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return b == 16'h0 ? 17'h0 : {1'b0, a / b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    always_ff @(posedge clk or negedge RST)
        if (!RST) begin
            ALU_OUT_VLD <= 1'b0;
            ALU_OUT     <= '0;
            ALU_CARRY   <= 1'b0;
        end else begin
            ALU_OUT_VLD <= ALU_EN && unit_on;
            if (ALU_EN) {ALU_CARRY, ALU_OUT} <= unit_f(ALU_FUN, ALU_A, ALU_B);
        end

    always @(negedge clk) begin
        if (TX_D_VLD && TX_RDY) got.push_back(TX_D);
        if (ALU_EN) en_cnt++;
        if (TX_D_VLD) vld_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        RX_D = b;
        RX_D_VLD = 1'b1;
        @(posedge clk);
        #1;
        RX_D_VLD = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_cc(input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
        send(8'hCC); send(a[7:0]); send(a[15:8]); send(b[7:0]); send(b[15:8]); send(f);
        ma = a;
        mb = b;
        mfun = f[3:0];
    endtask

    task automatic frame_dd(input logic [7:0] f);
        send(8'hDD); send(f);
        mfun = f[3:0];
    endtask

    // expected response of the frame just sent, from the held model operands
    task automatic expect_resp(input logic [7:0] f, input bit ov, output bit err);
        logic [16:0] r;
        err = f[7:4] != 4'h0 || (f[3:0] == 4'd3 && mb == 16'h0);
        r = unit_f(f[3:0], ma, mb);
        expq.delete();
        if (err) expq.push_back(8'hEE);
        else begin
            expq.push_back(r[7:0]);
            expq.push_back(r[15:8]);
            expq.push_back({6'b0, ov, r[16]});
        end
    endtask

    task automatic collect(input int base, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (got.size() - base >= expq.size()) break;
            TX_RDY = rand_rdy ? 1'($urandom % 2) : 1'b1;
            @(posedge clk);
            #1;
        end
        TX_RDY = 1'b1;
        chk($sformatf("%s_cnt", tag), got.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (base + i < got.size()) ? {24'h0, got[base + i]} : 32'hFFFF, {24'h0, expq[i]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, e0, v0, n;
        bit err, ov, cc;
        logic [15:0] ra, rb;
        logic [7:0] rf;

        #2;
        chk("rst_alu_a", ALU_A, 0);
        chk("rst_alu_b", ALU_B, 0);
        chk("rst_alu_fun", ALU_FUN, 0);
        chk("rst_alu_en", ALU_EN, 0);
        chk("rst_tx_d", TX_D, 0);
        chk("rst_tx_vld", TX_D_VLD, 0);
        tick(2);
        RST = 1'b1;
        tick(1);

        // full add with latency checks
        base = got.size(); e0 = en_cnt;
        frame_cc(16'h1234, 16'h0001, 8'h00);
        chk("lat_en_k", ALU_EN, 1);
        tick(1);
        chk("lat_en_k1", ALU_EN, 0);
        chk("lat_vld_k1", TX_D_VLD, 0);
        tick(1);
        chk("lat_vld_k2", TX_D_VLD, 1);
        chk("lat_txd_k2", TX_D, 8'h35);
        expq = '{8'h35, 8'h12, 8'h00};
        collect(base, "add");
        chk("add_en", en_cnt - e0, 1);

        // function reuse with backpressure
        TX_RDY = 1'b0;
        base = got.size();
        frame_dd(8'h01);
        for (int i = 0; i < 10 && !TX_D_VLD; i++) tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", TX_D_VLD, 1);
            chk("bp_txd", TX_D, 8'h33);
            tick(1);
        end
        chk("bp_none", got.size() - base, 0);
        TX_RDY = 1'b1;
        expq = '{8'h33, 8'h12, 8'h00};
        collect(base, "sub");

        // errors
        base = got.size(); e0 = en_cnt;
        frame_cc(16'h0000, 16'h0000, 8'h03);
        expq = '{8'hEE};
        collect(base, "div0");
        chk("div0_en", en_cnt - e0, 0);
        base = got.size(); e0 = en_cnt;
        frame_dd(8'h1F);
        collect(base, "badfun");
        chk("badfun_en", en_cnt - e0, 0);

        // timeout
        unit_on = 1'b0;
        TX_RDY = 1'b0;
        base = got.size();
        frame_cc(16'h0005, 16'h0000, 8'h00);
        n = 0;
        for (int i = 0; i < 20 && !TX_D_VLD; i++) begin
            tick(1);
            n++;
        end
        chk("timeout_cyc", n - 1, 4);
        chk("timeout_txd", TX_D, 8'hEE);
        TX_RDY = 1'b1;
        expq = '{8'hEE};
        collect(base, "timeout");
        unit_on = 1'b1;

        // overrun during WAIT
        base = got.size();
        frame_cc(16'h1234, 16'h0001, 8'h00);
        tick(1);
        send(8'hAA);
        expq = '{8'h35, 8'h12, 8'h02};
        collect(base, "ovr");
        base = got.size();
        frame_dd(8'h00);
        expq = '{8'h35, 8'h12, 8'h00};
        collect(base, "ovr_clr");

        // reset mid-frame
        send(8'hCC); send(8'h11); send(8'h22);
        RST = 1'b0;
        #2;
        chk("mid_rst_a", ALU_A, 0);
        chk("mid_rst_vld", TX_D_VLD, 0);
        tick(1);
        RST = 1'b1;
        tick(1);
        v0 = vld_cnt; e0 = en_cnt;
        send(8'h55);
        tick(8);
        chk("mid_rst_novld", vld_cnt - v0, 0);
        chk("mid_rst_noen", en_cnt - e0, 0);
        base = got.size();
        frame_cc(16'h1234, 16'h0001, 8'h00);
        expq = '{8'h35, 8'h12, 8'h00};
        collect(base, "post_rst");

        // randomized frames against the model
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            base = got.size(); e0 = en_cnt;
            cc = (i == 0) || ($urandom % 2 == 1);
            ra = 16'($urandom);
            rb = ($urandom % 4 == 0) ? 16'h0 : 16'($urandom);
            rf = ($urandom % 6 == 0) ? {4'($urandom_range(1, 15)), 4'($urandom)} : {4'h0, 4'($urandom % 5)};
            if (cc) frame_cc(ra, rb, rf);
            else frame_dd(rf);
            err = rf[7:4] != 4'h0 || (rf[3:0] == 4'd3 && mb == 16'h0);
            ov = !err && ($urandom % 3 == 0);
            if (ov) send(8'hAA);
            expect_resp(rf, ov, err);
            collect(base, $sformatf("rnd%0d", i));
            chk("rnd_en", en_cnt - e0, err ? 0 : 1);
            chk("rnd_a", ALU_A, ma);
            chk("rnd_b", ALU_B, mb);
            chk("rnd_fun", ALU_FUN, mfun);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
